// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch run-control block: FSM state
// encoding, button indices and default debounce length.
package stopwatch_pkg;

    // Run-control states; the codes are also shown on the debug LEDs.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10,
        LAP    = 2'b11
    } sw_state_t;

    // 20 ms at a 5 MHz system clock.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 100000;

    // Button slots in the conditioned press vector.
    localparam int BTN_SS   = 0;
    localparam int BTN_LAP  = 1;
    localparam int NUM_BTNS = 2;

    // True for states in which the counter chain is halted.
    function automatic logic state_stops(input sw_state_t s);
        return (s == IDLE) || (s == PAUSED);
    endfunction

    // True for the state in which the display is frozen on a split time.
    function automatic logic state_holds(input sw_state_t s);
        return (s == LAP);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton front end: two-flop synchronizer, a retiming flop,
// a stability counter that accepts a new level only after it has been
// seen for DEBOUNCE_CYCLES consecutive cycles, and a registered
// single-cycle pulse on each accepted press (0->1 of the clean level).
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk_main,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_reg;
    logic             lvl_reg;
    logic             db_reg;
    logic             db_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             db_prev_reg;
    logic             press_reg;

    // Bring the raw button into clk_main, then retime once so the
    // comparator below is fed from a plain flop rather than the sync chain.
    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            sync_reg <= 2'b00;
            lvl_reg  <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], btn_raw};
            lvl_reg  <= sync_reg[1];
        end
    end

    // Count consecutive cycles the input disagrees with the accepted level;
    // any agreement restarts the count, so short glitches never flip it.
    always_comb begin
        db_next  = db_reg;
        cnt_next = cnt_reg;
        if (lvl_reg == db_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
            db_next  = ~db_reg;
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // Debounced level and counter registers.
    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            db_reg  <= 1'b0;
            cnt_reg <= '0;
        end else begin
            db_reg  <= db_next;
            cnt_reg <= cnt_next;
        end
    end

    // Registered rising-edge detect; releases produce no pulse.
    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            db_prev_reg <= 1'b0;
            press_reg   <= 1'b0;
        end else begin
            db_prev_reg <= db_reg;
            press_reg   <= db_reg & ~db_prev_reg;
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run control: conditions the start/stop and lap/clear buttons
// into press events and sequences IDLE/RUN/PAUSED/LAP, driving the
// counter chain's stop level, clear pulse and display-hold level.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk_main,
    input  logic       reset,
    input  logic       btn_ss,
    input  logic       btn_lap,
    output logic       stop,
    output logic       clr,
    output logic       lap_hold,
    output logic [1:0] state
);

    logic [NUM_BTNS-1:0] raw_btn;
    logic [NUM_BTNS-1:0] press;

    logic      ss_evt;
    logic      lap_evt;

    sw_state_t state_reg;
    sw_state_t state_next;
    logic      clr_next;
    logic      stop_reg;
    logic      lap_hold_reg;
    logic      clr_reg;

    assign raw_btn[BTN_SS]  = btn_ss;
    assign raw_btn[BTN_LAP] = btn_lap;

    // Identical front end per button.
    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_debounce (
                .clk_main (clk_main),
                .reset    (reset),
                .btn_raw  (raw_btn[gi]),
                .press    (press[gi])
            );
        end
    endgenerate

    // Start/stop has priority: a lap press in the same cycle is dropped.
    assign ss_evt  = press[BTN_SS];
    assign lap_evt = press[BTN_LAP] & ~press[BTN_SS];

    // Next state and clear request from the current state and press events.
    always_comb begin
        state_next = state_reg;
        clr_next   = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (ss_evt) begin
                    state_next = RUN;
                end else if (lap_evt) begin
                    clr_next = 1'b1;    // re-clear is harmless
                end
            end
            RUN: begin
                if (ss_evt) begin
                    state_next = PAUSED;
                end else if (lap_evt) begin
                    state_next = LAP;
                end
            end
            PAUSED: begin
                if (ss_evt) begin
                    state_next = RUN;
                end else if (lap_evt) begin
                    state_next = IDLE;
                    clr_next   = 1'b1;
                end
            end
            LAP: begin
                if (ss_evt) begin
                    state_next = PAUSED;
                end else if (lap_evt) begin
                    state_next = RUN;
                end
            end
        endcase
    end

    // State and outputs registered together so every output is a clean
    // flop that changes on the same edge as the state.
    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            stop_reg     <= 1'b1;
            lap_hold_reg <= 1'b0;
            clr_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            stop_reg     <= state_stops(state_next);
            lap_hold_reg <= state_holds(state_next);
            clr_reg      <= clr_next;
        end
    end

    assign stop     = stop_reg;
    assign lap_hold = lap_hold_reg;
    assign clr      = clr_reg;
    assign state    = state_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4. A reference
// model samples the raw buttons each cycle, accepts a level once it has
// been seen for DEBOUNCE_CYCLES samples in a row, schedules the resulting
// press a fixed latency later, applies the run-control rules and queues the
// expected outputs. A separate monitor pops and compares on each falling edge.
module tb_stopwatch_ctrl;

    localparam int DC      = 4;
    // Edges from the last required raw sample to the output change:
    // 2 sync + 1 retime flip of the clean level, +1 pulse, +1 state.
    localparam int EVT_LAT = 5;

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_RUN    = 2'b01;
    localparam logic [1:0] S_PAUSED = 2'b10;
    localparam logic [1:0] S_LAP    = 2'b11;

    typedef struct packed {
        logic [1:0] st;
        logic       stop;
        logic       hold;
        logic       clr;
    } exp_t;

    logic       clk_main = 1'b0;
    logic       reset    = 1'b1;
    logic       btn_ss   = 1'b0;
    logic       btn_lap  = 1'b0;
    logic       stop;
    logic       clr;
    logic       lap_hold;
    logic [1:0] state;

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk_main (clk_main),
        .reset    (reset),
        .btn_ss   (btn_ss),
        .btn_lap  (btn_lap),
        .stop     (stop),
        .clr      (clr),
        .lap_hold (lap_hold),
        .state    (state)
    );

    always #5 clk_main = ~clk_main;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t last_exp;

    // Reference model state
    int         edge_no = 0;
    int         run_len[2];
    bit         acc_lvl[2];
    int         due_ss[$];
    int         due_lap[$];
    logic [1:0] m_mode = S_IDLE;

    function automatic exp_t outputs_for(input logic [1:0] mode, input logic cleared);
        exp_t e;
        e.st   = mode;
        e.stop = (mode == S_IDLE) || (mode == S_PAUSED);
        e.hold = (mode == S_LAP);
        e.clr  = cleared;
        return e;
    endfunction

    task automatic model_reset();
        run_len = '{default: 0};
        acc_lvl = '{default: 0};
        due_ss.delete();
        due_lap.delete();
        exp_q.delete();
        m_mode = S_IDLE;
    endtask

    task automatic sample(input int b, input logic raw);
        if (raw != acc_lvl[b]) run_len[b]++;
        else                   run_len[b] = 0;
        if (run_len[b] == DC) begin
            acc_lvl[b] = raw;
            run_len[b] = 0;
            if (raw) begin
                if (b == 0) due_ss.push_back(edge_no + EVT_LAT);
                else        due_lap.push_back(edge_no + EVT_LAT);
            end
        end
    endtask

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at t=%0t: actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    // Asynchronous reset discards everything in flight.
    always @(posedge reset) model_reset();

    // Reference model: one step per rising edge outside reset.
    always @(posedge clk_main) begin
        if (reset) begin
            model_reset();
        end else begin
            bit         ss_e;
            bit         lap_e;
            logic       cleared;
            logic [1:0] nxt;
            edge_no++;
            sample(0, btn_ss);
            sample(1, btn_lap);
            ss_e  = (due_ss.size() > 0) && (due_ss[0] == edge_no);
            lap_e = (due_lap.size() > 0) && (due_lap[0] == edge_no);
            if (ss_e)  void'(due_ss.pop_front());
            if (lap_e) void'(due_lap.pop_front());
            if (ss_e) lap_e = 1'b0;
            nxt     = m_mode;
            cleared = 1'b0;
            if (ss_e) begin
                nxt = (m_mode == S_RUN || m_mode == S_LAP) ? S_PAUSED : S_RUN;
            end else if (lap_e) begin
                if (m_mode == S_RUN)      nxt = S_LAP;
                else if (m_mode == S_LAP) nxt = S_RUN;
                else begin
                    nxt     = S_IDLE;
                    cleared = 1'b1;
                end
            end
            m_mode = nxt;
            exp_q.push_back(outputs_for(nxt, cleared));
        end
    end

    // Monitor: compare DUT outputs against the scoreboard mid-cycle.
    always @(negedge clk_main) begin
        exp_t e;
        if (reset) begin
            e = outputs_for(S_IDLE, 1'b0);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e = last_exp;
        end
        last_exp = e;
        check("state",    state,           e.st);
        check("stop",     {1'b0, stop},     {1'b0, e.stop});
        check("lap_hold", {1'b0, lap_hold}, {1'b0, e.hold});
        check("clr",      {1'b0, clr},      {1'b0, e.clr});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_main);
            #1;
        end
    endtask

    task automatic drive(input logic ss, input logic lap, input int n, input string tag);
        btn_ss  = ss;
        btn_lap = lap;
        tick(n);
        $display("txn %-14s ss=%0b lap=%0b cycles=%0d -> state=%0d stop=%0b hold=%0b",
                 tag, ss, lap, n, state, stop, lap_hold);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        $display("txn reset pulse  state=%0d stop=%0b hold=%0b", state, stop, lap_hold);
    endtask

    initial begin
        last_exp = outputs_for(S_IDLE, 1'b0);
        model_reset();
        tick(5);
        reset = 1'b0;
        drive(0, 0, 10, "idle");

        // start: IDLE -> RUN, held button gives a single event
        drive(1, 0, 20, "ss held");
        drive(0, 0, 10, "release");

        // glitches of 1, 2, 3 cycles: no event
        drive(1, 0, 1, "glitch1");
        drive(0, 0, 1, "gap");
        drive(1, 0, 2, "glitch2");
        drive(0, 0, 1, "gap");
        drive(1, 0, 3, "glitch3");
        drive(0, 0, 10, "quiet");

        // RUN -> LAP -> RUN -> PAUSED -> IDLE (clear)
        drive(0, 1, 10, "lap");
        drive(0, 0, 10, "release");
        drive(0, 1, 10, "lap");
        drive(0, 0, 10, "release");
        drive(1, 0, 10, "ss");
        drive(0, 0, 10, "release");
        drive(0, 1, 10, "lap clear");
        drive(0, 0, 10, "release");
        drive(0, 1, 10, "lap reclear");
        drive(0, 0, 10, "release");

        // RUN, then both buttons together -> PAUSED
        drive(1, 0, 10, "ss");
        drive(0, 0, 10, "release");
        drive(1, 1, 10, "both");
        drive(0, 0, 10, "release");

        // PAUSED -> RUN -> LAP, then reset mid-debounce with ss held
        drive(1, 0, 10, "ss");
        drive(0, 0, 10, "release");
        drive(0, 1, 10, "lap");
        drive(0, 0, 10, "release");
        drive(1, 0, 2, "ss partial");
        pulse_reset();
        drive(1, 0, 15, "ss thru reset");
        drive(0, 0, 10, "release");

        // randomized button activity with occasional resets
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                pulse_reset();
            end else begin
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(1, 14), "random");
            end
        end
        drive(0, 0, 20, "drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not complete, failures so far=%0d", n_fail);
        $fatal(1, "timeout");
    end

endmodule
